// File: rtl/parking_zone_counter_if.sv
// Sensor inputs and per-zone status outputs of the parking zone counter.
interface parking_zone_counter_if;
  logic [3:0]  entry_req;
  logic [3:0]  exit_req;
  logic [11:0] free_spaces;
  logic [3:0]  zone_full;
  logic [3:0]  gate_open;
  logic [3:0]  rejected;
  logic [3:0]  exit_err;

  modport master (
    output entry_req, exit_req,
    input  free_spaces, zone_full, gate_open, rejected, exit_err
  );

  modport slave (
    input  entry_req, exit_req,
    output free_spaces, zone_full, gate_open, rejected, exit_err
  );
endinterface

// File: rtl/parking_zone_counter.sv
// Four-zone parking space tracker: sensor sync/debounce, occupancy counting
// and a timed entry barrier per zone.
module parking_zone_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GATE_CYCLES     = 1000,
  parameter int unsigned CAPACITY        = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  parking_zone_counter_if.slave bus
);

  localparam int unsigned NZ  = 4;
  localparam int unsigned NS  = 2 * NZ;
  localparam int unsigned CW  = 3;
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] CAP3 = CW'(CAPACITY);

  if (CAPACITY < 1 || CAPACITY > 7) begin : g_cap_check
    $error("parking_zone_counter: CAPACITY must be in 1..7");
  end

  typedef enum logic {IDLE, OPEN} gate_state_t;

  // Sensor vector: entries in [3:0], exits in [7:4]
  logic [NS-1:0]  raw;
  logic [NS-1:0]  sync1, sync2, deb, deb_d, evt;
  logic [DCW-1:0] cnt [NS];

  assign raw = {bus.exit_req, bus.entry_req};

  // Synchronize, debounce and extract rising-edge events
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      evt   <= '0;
      for (int i = 0; i < NS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      evt   <= deb & ~deb_d;
      for (int i = 0; i < NS; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DCW'(1);
        end
      end
    end
  end

  gate_state_t   state      [NZ];
  gate_state_t   state_next [NZ];
  logic [TW-1:0] timer      [NZ];
  logic [TW-1:0] timer_next [NZ];
  logic [CW-1:0] free       [NZ];
  logic [CW-1:0] free_next  [NZ];
  logic [NZ-1:0] acc_entry_c, acc_exit_c;

  // Accept decisions, count update and gate FSM next state
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    free_next   = free;
    acc_entry_c = '0;
    acc_exit_c  = '0;
    for (int z = 0; z < NZ; z++) begin
      acc_entry_c[z] = evt[z] & (state[z] == IDLE) & ((free[z] != '0) | evt[NZ+z]);
      acc_exit_c[z]  = evt[NZ+z] & ((free[z] < CAP3) | acc_entry_c[z]);
      free_next[z]   = free[z] + CW'(acc_exit_c[z]) - CW'(acc_entry_c[z]);
      case (state[z])
        IDLE: begin
          if (acc_entry_c[z]) begin
            state_next[z] = OPEN;
            timer_next[z] = TW'(GATE_CYCLES - 1);
          end
        end
        OPEN: begin
          if (timer[z] == '0) state_next[z] = IDLE;
          else                timer_next[z] = timer[z] - TW'(1);
        end
        default: state_next[z] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= '{default: IDLE};
      timer         <= '{default: '0};
      free          <= '{default: CAP3};
      bus.zone_full <= '0;
      bus.gate_open <= '0;
      bus.rejected  <= '0;
      bus.exit_err  <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      free  <= free_next;
      for (int z = 0; z < NZ; z++) begin
        bus.zone_full[z] <= (free_next[z] == '0);
        bus.gate_open[z] <= (state_next[z] == OPEN);
        bus.rejected[z]  <= evt[z] & ~acc_entry_c[z];
        bus.exit_err[z]  <= evt[NZ+z] & ~acc_exit_c[z];
      end
    end
  end

  assign bus.free_spaces = {free[3], free[2], free[1], free[0]};

endmodule

// File: tb/tb_parking_zone_counter.sv
// Directed bench: main instance with CAPACITY=7 plus a CAPACITY=1 instance for full-zone cases.
module tb_parking_zone_counter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  parking_zone_counter_if bif ();
  parking_zone_counter_if bif1 ();

  parking_zone_counter #(.DEBOUNCE_CYCLES(4), .GATE_CYCLES(8), .CAPACITY(7)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  parking_zone_counter #(.DEBOUNCE_CYCLES(4), .GATE_CYCLES(8), .CAPACITY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bif.entry_req  = '0;
    bif.exit_req   = '0;
    bif1.entry_req = '0;
    bif1.exit_req  = '0;
    step(2);
    chk("rst_free",      bif.free_spaces,        12'hFFF);
    chk("rst_full",      12'(bif.zone_full),     12'h0);
    chk("rst_gate",      12'(bif.gate_open),     12'h0);
    chk("rst_rej",       12'(bif.rejected),      12'h0);
    chk("rst_exit_err",  12'(bif.exit_err),      12'h0);
    chk("rst_free_cap1", bif1.free_spaces,       12'h249);
    rst = 1'b0;
    step(3);

    // 3-cycle glitch must not be accepted
    bif.entry_req[0] = 1'b1;
    step(3);
    bif.entry_req[0] = 1'b0;
    step(10);
    chk("glitch_free", 12'(bif.free_spaces[2:0]), 12'd7);
    chk("glitch_gate", 12'(bif.gate_open[0]),     12'd0);

    // Stable entry: accepted 8 cycles after the raw edge, gate high 8 cycles
    bif.entry_req[0] = 1'b1;
    step(7);
    chk("z0_before",   12'(bif.free_spaces[2:0]), 12'd7);
    chk("z0_gate_pre", 12'(bif.gate_open[0]),     12'd0);
    step(1);
    chk("z0_after",    12'(bif.free_spaces[2:0]), 12'd6);
    chk("z0_gate_on",  12'(bif.gate_open[0]),     12'd1);
    step(2);
    bif.entry_req[0] = 1'b0;
    step(5);
    chk("z0_gate_last", 12'(bif.gate_open[0]), 12'd1);
    step(1);
    chk("z0_gate_off",  12'(bif.gate_open[0]), 12'd0);
    step(4);

    // Two entry events 8 cycles apart: second lands on the last OPEN cycle
    bif.entry_req[0] = 1'b1;
    step(4);
    bif.entry_req[0] = 1'b0;
    step(4);
    bif.entry_req[0] = 1'b1;
    chk("busy_first_free", 12'(bif.free_spaces[2:0]), 12'd5);
    chk("busy_first_gate", 12'(bif.gate_open[0]),     12'd1);
    step(7);
    chk("busy_rej_pre",  12'(bif.rejected[0]),        12'd0);
    step(1);
    chk("busy_rej",      12'(bif.rejected[0]),        12'd1);
    chk("busy_free",     12'(bif.free_spaces[2:0]),   12'd5);
    chk("busy_gate_off", 12'(bif.gate_open[0]),       12'd0);
    step(1);
    chk("busy_rej_end",  12'(bif.rejected[0]),        12'd0);
    bif.entry_req[0] = 1'b0;
    step(10);

    // CAPACITY=1 instance, zone 2: fill, reject, then exit
    bif1.entry_req[2] = 1'b1;
    step(7);
    chk("full_pre",  12'(bif1.free_spaces[8:6]), 12'd1);
    step(1);
    chk("full_free", 12'(bif1.free_spaces[8:6]), 12'd0);
    chk("full_flag", 12'(bif1.zone_full),        12'h4);
    chk("full_gate", 12'(bif1.gate_open[2]),     12'd1);
    bif1.entry_req[2] = 1'b0;
    step(12);
    chk("full_gate_off", 12'(bif1.gate_open[2]), 12'd0);
    bif1.entry_req[2] = 1'b1;
    step(8);
    chk("full_rej",      12'(bif1.rejected),          12'h4);
    chk("full_rej_free", 12'(bif1.free_spaces[8:6]),  12'd0);
    chk("full_rej_flag", 12'(bif1.zone_full[2]),      12'd1);
    step(1);
    chk("full_rej_end",  12'(bif1.rejected[2]),       12'd0);
    bif1.entry_req[2] = 1'b0;
    bif1.exit_req[2]  = 1'b1;
    step(8);
    chk("full_exit_free", 12'(bif1.free_spaces[8:6]), 12'd1);
    chk("full_exit_flag", 12'(bif1.zone_full[2]),     12'd0);
    chk("full_exit_err",  12'(bif1.exit_err[2]),      12'd0);
    bif1.exit_req[2] = 1'b0;

    // Zone 3 exit at capacity
    bif.exit_req[3] = 1'b1;
    step(7);
    chk("cap_err_pre", 12'(bif.exit_err[3]), 12'd0);
    step(1);
    chk("cap_err",      12'(bif.exit_err),          12'h8);
    chk("cap_err_free", 12'(bif.free_spaces[11:9]), 12'd7);
    step(1);
    chk("cap_err_end",  12'(bif.exit_err[3]),       12'd0);
    bif.exit_req[3] = 1'b0;
    step(10);

    // Simultaneous entry+exit at capacity
    bif.entry_req[3] = 1'b1;
    bif.exit_req[3]  = 1'b1;
    step(8);
    chk("sim_free",   12'(bif.free_spaces[11:9]), 12'd7);
    chk("sim_gate",   12'(bif.gate_open[3]),      12'd1);
    chk("sim_err",    12'(bif.exit_err[3]),       12'd0);
    chk("sim_rej",    12'(bif.rejected[3]),       12'd0);
    chk("sim_other",  12'(bif.free_spaces[2:0]),  12'd5);
    bif.entry_req[3] = 1'b0;
    bif.exit_req[3]  = 1'b0;

    // Zone 1 down to 5, then reset while its gate is open
    bif.entry_req[1] = 1'b1;
    step(8);
    chk("z1_first", 12'(bif.free_spaces[5:3]), 12'd6);
    bif.entry_req[1] = 1'b0;
    step(10);
    bif.entry_req[1] = 1'b1;
    step(8);
    chk("z1_second", 12'(bif.free_spaces[5:3]), 12'd5);
    chk("z1_gate",   12'(bif.gate_open[1]),     12'd1);
    step(2);
    rst = 1'b1;
    step(1);
    chk("mid_rst_gate", 12'(bif.gate_open),  12'h0);
    chk("mid_rst_free", bif.free_spaces,     12'hFFF);
    rst = 1'b0;
    step(7);
    chk("held_pre",      12'(bif.free_spaces[5:3]), 12'd7);
    chk("held_gate_pre", 12'(bif.gate_open[1]),     12'd0);
    step(1);
    chk("held_free", 12'(bif.free_spaces[5:3]), 12'd6);
    chk("held_gate", 12'(bif.gate_open[1]),     12'd1);
    step(10);
    chk("held_once", 12'(bif.free_spaces[5:3]), 12'd6);
    bif.entry_req[1] = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
